// File: rtl/zap_pkg.sv
// Shared types and constants for the Zapper flash/hit-test sequencer.
package zap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLANK,
    TARGET,
    RESULT,
    COOLDOWN
  } zap_state_e;

  localparam int unsigned TIDX_W = 4;
  localparam int unsigned PLYR_W = 16;

  localparam int unsigned SHOT_BIT  = 0;
  localparam int unsigned HIT_BIT   = 1;
  localparam int unsigned CHEAT_BIT = 2;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef struct packed {
    logic [PLYR_W-4:0] rsvd;
    logic              cheat;
    logic              hit;
    logic              shot;
  } plyr_input_t;

  // Builds the word game logic reads after a completed shot.
  function automatic plyr_input_t pack_plyr(input logic cheat, input logic hit);
    plyr_input_t p;
    p       = '0;
    p.cheat = cheat;
    p.hit   = hit;
    p.shot  = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/zap_debounce.sv
// Trigger synchroniser + stability-counter debounce; emits a one-clock press
// pulse on the falling edge of the debounced (active-low) trigger.
module zap_debounce
  import zap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   trig_s;
  logic                   stable_c;

  assign trig_s   = sync_q[SYNC_STAGES-1];
  assign stable_c = (trig_s == prev_q);

  // Counter restarts on any change; level follows only after a full stable window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (stable_c) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_MAX) begin
        level_d = trig_s;
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], trigger_n_i};
      prev_q  <= trig_s;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/zapper_flash_seq.sv
// Zapper hit-test sequencer: black frame(s), one white target per frame, sensor sampling.
// Optional ZAP_LIGHT_CHECK_EN: light seen during BLANK flags cheat and skips the targets.
module zapper_flash_seq
  import zap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned BLANK_FRAMES    = 1,
  parameter int unsigned NUM_TARGETS     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger_n,
  input  logic              sensor,
  input  logic              frame_start,
  output logic              blank_screen,
  output logic              show_target,
  output logic [TIDX_W-1:0] target_idx,
  output logic              busy,
  output logic              result_valid,
  output logic [TIDX_W-1:0] hit_idx,
  output logic [PLYR_W-1:0] plyr_input
);

  localparam int unsigned FRAMES_MAX =
    (BLANK_FRAMES > COOLDOWN_FRAMES) ? BLANK_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned FCNT_W = $clog2(FRAMES_MAX + 1);
  localparam logic [FCNT_W-1:0] BLANK_LAST = FCNT_W'(BLANK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] COOL_LAST  = FCNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [TIDX_W-1:0] TGT_LAST   = TIDX_W'(NUM_TARGETS - 1);

  logic press;
  logic [SYNC_STAGES-1:0] sensor_sync_q;
  logic sensor_s;
  logic sensor_blank_c;

  zap_state_e        state_q, state_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TIDX_W-1:0] tidx_q, tidx_d;
  logic [TIDX_W-1:0] hit_lat_q, hit_lat_d;
  logic              hit_q, hit_d;
  logic              cheat_q, cheat_d;

  logic              blank_q, blank_d;
  logic              show_q, show_d;
  logic [TIDX_W-1:0] target_idx_q, target_idx_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic [TIDX_W-1:0] hit_idx_q, hit_idx_d;
  plyr_input_t       plyr_q, plyr_d;

  zap_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .trigger_n_i(trigger_n),
    .press_o    (press)
  );

  assign sensor_s = sensor_sync_q[SYNC_STAGES-1];

`ifdef ZAP_LIGHT_CHECK_EN
  assign sensor_blank_c = sensor_s;
`else
  assign sensor_blank_c = 1'b0;
`endif

  // Next-state and registered-output decode; outputs follow the next state.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    tidx_d       = tidx_q;
    hit_lat_d    = hit_lat_q;
    hit_d        = hit_q;
    cheat_d      = cheat_q;
    rv_d         = 1'b0;
    hit_idx_d    = hit_idx_q;
    plyr_d       = plyr_q;
    blank_d      = 1'b0;
    show_d       = 1'b0;
    target_idx_d = '0;
    busy_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (press) begin
          state_d   = ARM;
          tidx_d    = '0;
          hit_d     = 1'b0;
          hit_lat_d = '0;
          cheat_d   = 1'b0;
        end
      end
      ARM: begin
        if (frame_start) begin
          state_d     = BLANK;
          frame_cnt_d = '0;
        end
      end
      BLANK: begin
        if (sensor_blank_c) begin
          cheat_d = 1'b1;
        end
        if (frame_start) begin
          if (frame_cnt_q == BLANK_LAST) begin
            frame_cnt_d = '0;
            tidx_d      = '0;
            state_d     = cheat_d ? RESULT : TARGET;
          end else begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          end
        end
      end
      TARGET: begin
        if (sensor_s && !hit_q) begin
          hit_d     = 1'b1;
          hit_lat_d = tidx_q;
        end
        if (frame_start) begin
          if (hit_d || (tidx_q == TGT_LAST)) begin
            state_d = RESULT;
          end else begin
            tidx_d = tidx_q + TIDX_W'(1);
          end
        end
      end
      RESULT: begin
        state_d     = COOLDOWN;
        frame_cnt_d = '0;
      end
      COOLDOWN: begin
        if (frame_start) begin
          if (frame_cnt_q == COOL_LAST) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    blank_d = (state_d == BLANK) || (state_d == TARGET);
    show_d  = (state_d == TARGET);
    busy_d  = (state_d == ARM) || (state_d == BLANK) ||
              (state_d == TARGET) || (state_d == RESULT);
    if (state_d == TARGET) begin
      target_idx_d = tidx_d;
    end
    if (state_d == RESULT) begin
      rv_d      = 1'b1;
      plyr_d    = pack_plyr(cheat_d, hit_d);
      hit_idx_d = hit_d ? hit_lat_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sensor_sync_q <= '0;
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      tidx_q        <= '0;
      hit_lat_q     <= '0;
      hit_q         <= 1'b0;
      cheat_q       <= 1'b0;
      blank_q       <= 1'b0;
      show_q        <= 1'b0;
      target_idx_q  <= '0;
      busy_q        <= 1'b0;
      rv_q          <= 1'b0;
      hit_idx_q     <= '0;
      plyr_q        <= '0;
    end else begin
      sensor_sync_q <= {sensor_sync_q[SYNC_STAGES-2:0], sensor};
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      tidx_q        <= tidx_d;
      hit_lat_q     <= hit_lat_d;
      hit_q         <= hit_d;
      cheat_q       <= cheat_d;
      blank_q       <= blank_d;
      show_q        <= show_d;
      target_idx_q  <= target_idx_d;
      busy_q        <= busy_d;
      rv_q          <= rv_d;
      hit_idx_q     <= hit_idx_d;
      plyr_q        <= plyr_d;
    end
  end

  assign blank_screen = blank_q;
  assign show_target  = show_q;
  assign target_idx   = target_idx_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign hit_idx      = hit_idx_q;
  assign plyr_input   = plyr_q;

endmodule

// File: tb/tb_zapper_flash_seq.sv
// Bench for zapper_flash_seq: per-shot expected timeline built up front, checked every cycle.
module tb_zapper_flash_seq;

  localparam int SYNC      = 2;
  localparam int DB        = 4;
  localparam int BLANK_FR  = 1;
  localparam int NUM_T     = 4;
  localparam int COOL_FR   = 2;
  localparam int FPER      = 100;
  localparam int FOFF      = 50;
  localparam int NCYC      = 4100;
  // Raw pull applied in cycle t -> busy first seen in cycle t+PRESS_LAT
  // (sync stages, DB+1 stable samples, press register, state register).
  localparam int PRESS_LAT = SYNC + DB + 2;

`ifdef ZAP_LIGHT_CHECK_EN
  localparam bit LIGHT_CHECK = 1'b1;
`else
  localparam bit LIGHT_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger_n;
  logic        sensor;
  logic        frame_start;
  logic        blank_screen;
  logic        show_target;
  logic [3:0]  target_idx;
  logic        busy;
  logic        result_valid;
  logic [3:0]  hit_idx;
  logic [15:0] plyr_input;

  zapper_flash_seq #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .BLANK_FRAMES   (BLANK_FR),
    .NUM_TARGETS    (NUM_T),
    .COOLDOWN_FRAMES(COOL_FR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger_n   (trigger_n),
    .sensor      (sensor),
    .frame_start (frame_start),
    .blank_screen(blank_screen),
    .show_target (show_target),
    .target_idx  (target_idx),
    .busy        (busy),
    .result_valid(result_valid),
    .hit_idx     (hit_idx),
    .plyr_input  (plyr_input)
  );

  always #5 clk = ~clk;

  bit        rst_lo    [NCYC];
  bit        trig_low  [NCYC];
  bit        sensor_hi [NCYC];
  bit        exp_blank [NCYC];
  bit        exp_show  [NCYC];
  bit [3:0]  exp_tidx  [NCYC];
  bit        exp_busy  [NCYC];
  bit        exp_rv    [NCYC];
  bit [3:0]  exp_hidx  [NCYC];
  bit [15:0] exp_plyr  [NCYC];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rv_count = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  // One shot: trigger pulled at t for 10 clocks; hit_t = target seeing light (-1 none);
  // light_blank puts light in the black frame; abort_c = cycle with rst low (0 none).
  task automatic plan_shot(input int t, input int hit_t, input bit light_blank, input int abort_c);
    int b, f1, fs, fe, r, lim;
    bit cheat;
    bit [15:0] pv;
    lim   = (abort_c > 0) ? abort_c : NCYC - 1;
    cheat = light_blank & LIGHT_CHECK;
    for (int c = t; c < t + 10; c++) trig_low[c] = 1'b1;
    b  = t + PRESS_LAT;
    f1 = b;
    while (f1 % FPER != FOFF) f1++;
    if (light_blank) for (int c = f1 + 21; c <= f1 + 41; c++) sensor_hi[c] = 1'b1;
    if (hit_t >= 0) begin
      fs = f1 + FPER * (BLANK_FR + hit_t) + 1;
      for (int c = fs + 20; c <= fs + 40; c++) sensor_hi[c] = 1'b1;
    end
    fe = f1 + FPER * BLANK_FR;
    for (int c = f1 + 1; c <= fe; c++) if (c <= lim) exp_blank[c] = 1'b1;
    if (!cheat) begin
      for (int k = 0; k < NUM_T; k++) begin
        fs = fe + 1;
        fe = fe + FPER;
        for (int c = fs; c <= fe; c++) begin
          if (c <= lim) begin
            exp_blank[c] = 1'b1;
            exp_show[c]  = 1'b1;
            exp_tidx[c]  = 4'(k);
          end
        end
        if (k == hit_t) break;
      end
    end
    r = fe + 1;
    for (int c = b; c <= r; c++) if (c <= lim) exp_busy[c] = 1'b1;
    if (r <= lim) begin
      exp_rv[r] = 1'b1;
      pv = {13'd0, cheat, (hit_t >= 0), 1'b1};
      for (int c = r; c < NCYC; c++) begin
        exp_plyr[c] = pv;
        exp_hidx[c] = (hit_t >= 0) ? 4'(hit_t) : 4'd0;
      end
    end
    if (abort_c > 0) begin
      for (int c = abort_c + 1; c < NCYC; c++) begin
        exp_plyr[c] = 16'h0000;
        exp_hidx[c] = 4'd0;
      end
    end
  endtask

  task automatic drive(input int c);
    rst         = ~rst_lo[c];
    trigger_n   = ~trig_low[c];
    sensor      = sensor_hi[c];
    frame_start = (c % FPER == FOFF);
  endtask

  // Per-cycle model comparison plus literal anchors at known cycles.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (result_valid === 1'b1) rv_count++;
      chk("blank_screen", 16'(blank_screen), 16'(exp_blank[cyc]));
      chk("show_target",  16'(show_target),  16'(exp_show[cyc]));
      chk("target_idx",   16'(target_idx),   16'(exp_tidx[cyc]));
      chk("busy",         16'(busy),         16'(exp_busy[cyc]));
      chk("result_valid", 16'(result_valid), 16'(exp_rv[cyc]));
      chk("hit_idx",      16'(hit_idx),      16'(exp_hidx[cyc]));
      chk("plyr_input",   plyr_input,        exp_plyr[cyc]);
      case (cyc)
        3:    chk("lit_reset_plyr", plyr_input, 16'h0000);
        130:  chk("lit_glitch_busy", 16'(busy), 16'd0);
        207:  chk("lit_pre_busy", 16'(busy), 16'd0);
        208:  chk("lit_arm_busy", 16'(busy), 16'd1);
        651:  chk("lit_rv_a", 16'(result_valid), 16'd1);
        652: begin
          chk("lit_plyr_a", plyr_input, 16'h0003);
          chk("lit_hidx_a", 16'(hit_idx), 16'd2);
        end
        1000: chk("lit_fs_not_consumed", 16'(blank_screen), 16'd0);
        1220: chk("lit_ignored_tgt", 16'(show_target), 16'd1);
        1500: chk("lit_tidx3", 16'(target_idx), 16'd3);
        1552: begin
          chk("lit_plyr_b", plyr_input, 16'h0001);
          chk("lit_hidx_b", 16'(hit_idx), 16'd0);
        end
        1620: chk("lit_ignored_cool", 16'(busy), 16'd0);
        1808: chk("lit_after_cool", 16'(busy), 16'd1);
        2052: chk("lit_plyr_c", plyr_input, 16'h0003);
`ifdef ZAP_LIGHT_CHECK_EN
        2452: chk("lit_plyr_cheat", plyr_input, 16'h0005);
        2460: chk("lit_no_target", 16'(show_target), 16'd0);
`else
        2852: chk("lit_plyr_nocheat", plyr_input, 16'h0001);
`endif
        3301: begin
          chk("lit_rst_plyr", plyr_input, 16'h0000);
          chk("lit_rst_blank", 16'(blank_screen), 16'd0);
        end
        3852: begin
          chk("lit_plyr_f", plyr_input, 16'h0003);
          chk("lit_hidx_f", 16'(hit_idx), 16'd1);
        end
        default: ;
      endcase
    end
  end

  initial begin
    for (int c = 0; c < 5; c++) rst_lo[c] = 1'b1;
    for (int c = 120; c < 123; c++) trig_low[c] = 1'b1;
    plan_shot(200, 2, 1'b0, 0);
    plan_shot(943, -1, 1'b0, 0);
    for (int c = 1200; c < 1210; c++) trig_low[c] = 1'b1;
    for (int c = 1600; c < 1610; c++) trig_low[c] = 1'b1;
    plan_shot(1800, 0, 1'b0, 0);
    plan_shot(2300, -1, 1'b1, 0);
    plan_shot(3100, -1, 1'b0, 3300);
    rst_lo[3300] = 1'b1;
    plan_shot(3500, 1, 1'b0, 0);

    cyc = 0;
    drive(0);
    while (cyc < NCYC - 1) begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      drive(cyc);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("rv_pulse_count", 16'(rv_count), 16'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
